// File: rtl/registrador_universal.sv
// registrador_universal: multi-mode data register with single-cycle
// shift/rotate/inc/dec and a multi-cycle shift-by-N with busy/done handshake.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// OCIOSO     | idle, decodes controle on every edge
// DESLOCANDO | multi-cycle shift running, one bit per edge, inputs ignored
module registrador_universal #(
    parameter int WIDTH = 4,
    parameter int QW    = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] acumulador,
    input  logic [3:0]       controle,
    input  logic [QW-1:0]    quantidade,
    input  logic             entrada_serial,
    output logic [WIDTH-1:0] saida,
    output logic             carry,
    output logic             zero,
    output logic             ocupado,
    output logic             pronto
);

    localparam logic [3:0] OP_CLEAR = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_SHL   = 4'd3;
    localparam logic [3:0] OP_SHR   = 4'd4;
    localparam logic [3:0] OP_ROL   = 4'd5;
    localparam logic [3:0] OP_ROR   = 4'd6;
    localparam logic [3:0] OP_INC   = 4'd7;
    localparam logic [3:0] OP_DEC   = 4'd8;
    localparam logic [3:0] OP_SHLN  = 4'd9;
    localparam logic [3:0] OP_SHRN  = 4'd10;

    localparam logic [QW-1:0] AMT_MAX = QW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {OCIOSO, DESLOCANDO} estado_t;

    estado_t          state_q, state_d;
    logic [WIDTH-1:0] saida_q, saida_d;
    logic             carry_q, carry_d;
    logic             ocupado_q, ocupado_d;
    logic             pronto_q, pronto_d;
    logic             dir_q, dir_d;       // 1 = right
    logic [QW-1:0]    cont_q, cont_d;
    logic [QW-1:0]    amt;
    logic             multi_op;

    // Shift amounts beyond the register width are saturated to a full flush.
    assign amt      = (quantidade > AMT_MAX) ? AMT_MAX : quantidade;
    assign multi_op = (controle == OP_SHLN) || (controle == OP_SHRN);

    // State and datapath registers, all cleared by the async reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= OCIOSO;
            saida_q   <= '0;
            carry_q   <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            dir_q     <= 1'b0;
            cont_q    <= '0;
        end else begin
            state_q   <= state_d;
            saida_q   <= saida_d;
            carry_q   <= carry_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            dir_q     <= dir_d;
            cont_q    <= cont_d;
        end
    end

    // Next-state: enter DESLOCANDO only for a non-zero amount, leave on last step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OCIOSO:     if (multi_op && (amt != '0)) state_d = DESLOCANDO;
            DESLOCANDO: if (cont_q == ONE[QW-1:0])  state_d = OCIOSO;
            default:    state_d = OCIOSO;
        endcase
    end

    // Datapath and handshake next values; pronto defaults low so it pulses.
    always_comb begin
        saida_d   = saida_q;
        carry_d   = carry_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
        dir_d     = dir_q;
        cont_d    = cont_q;
        if (state_q == DESLOCANDO) begin
            if (dir_q) begin
                saida_d = {entrada_serial, saida_q[WIDTH-1:1]};
                carry_d = saida_q[0];
            end else begin
                saida_d = {saida_q[WIDTH-2:0], entrada_serial};
                carry_d = saida_q[WIDTH-1];
            end
            cont_d = cont_q - ONE[QW-1:0];
            if (cont_q == ONE[QW-1:0]) begin
                ocupado_d = 1'b0;
                pronto_d  = 1'b1;
            end
        end else begin
            case (controle)
                OP_CLEAR: begin
                    saida_d = '0;
                    carry_d = 1'b0;
                end
                OP_LOAD: begin
                    saida_d = acumulador;
                    carry_d = 1'b0;
                end
                OP_SHL: begin
                    saida_d = {saida_q[WIDTH-2:0], entrada_serial};
                    carry_d = saida_q[WIDTH-1];
                end
                OP_SHR: begin
                    saida_d = {entrada_serial, saida_q[WIDTH-1:1]};
                    carry_d = saida_q[0];
                end
                OP_ROL: begin
                    saida_d = {saida_q[WIDTH-2:0], saida_q[WIDTH-1]};
                    carry_d = saida_q[WIDTH-1];
                end
                OP_ROR: begin
                    saida_d = {saida_q[0], saida_q[WIDTH-1:1]};
                    carry_d = saida_q[0];
                end
                OP_INC: begin
                    saida_d = saida_q + ONE;
                    carry_d = &saida_q;
                end
                OP_DEC: begin
                    saida_d = saida_q - ONE;
                    carry_d = (saida_q == '0);
                end
                OP_SHLN, OP_SHRN: begin
                    if (amt == '0) begin
                        pronto_d = 1'b1;
                    end else begin
                        dir_d     = (controle == OP_SHRN);
                        cont_d    = amt;
                        ocupado_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign saida   = saida_q;
    assign carry   = carry_q;
    assign zero    = (saida_q == '0);
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

endmodule

// File: doc/registrador_universal.md
# registrador_universal

Parametrised, multi-mode data register that generalises the datapath's CLEAR/LOAD/HOLD registers to any width. Adds single-cycle shift, rotate, increment and decrement operations with carry and zero flags, and a multi-cycle shift-by-N operation with a busy/done handshake. It sits beside the accumulator: it loads from `acumulador` and drives `saida` back into the datapath under control-unit opcodes.

## Interface
- `WIDTH`, default 4: data width in bits; minimum 2.
- `QW`, default `$clog2(WIDTH)+1`: width of the shift-amount input, so that amounts up to `WIDTH` are representable.

Ports:
- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `acumulador`  in  WIDTH: load source.
- `controle`  in  4: opcode, sampled every edge while idle.
- `quantidade`  in  QW: shift amount for the multi-cycle ops.
- `entrada_serial`  in  1: fill bit for shifts.
- `saida`  out  WIDTH: register contents.
- `carry`  out  1: registered carry/borrow/shifted-out flag.
- `zero`  out  1: combinational, `saida == 0`.
- `ocupado`  out  1: registered; high while a multi-cycle shift runs.
- `pronto`  out  1: registered one-cycle pulse marking multi-cycle completion.

## Operation
Opcodes (`controle`):
- 0 CLEAR: `saida`←0, `carry`←0.
- 1 LOAD: `saida`←`acumulador`, `carry`←0.
- 2 HOLD: no change. Every undefined code (11–15) also behaves as HOLD.
- 3 SHL: `saida`←{`saida`[W-2:0], `entrada_serial`}; `carry`←old MSB.
- 4 SHR: `saida`←{`entrada_serial`, `saida`[W-1:1]}; `carry`←old LSB.
- 5 ROL and 6 ROR: rotate by one; `carry`←the bit that wrapped.
- 7 INC: `saida`←`saida`+1 mod 2^W; `carry`←1 only when old value was all-ones, else 0.
- 8 DEC: `saida`←`saida`−1 mod 2^W; `carry`←1 (borrow) only when old value was 0, else 0.
- 9 SHLN and 10 SHRN: multi-cycle shift left/right by `quantidade`, one bit per cycle.
  - Each step fills with `entrada_serial` sampled on that step's edge.
  - `carry` takes the last bit shifted out.

Multi-cycle state machine:
- OCIOSO
  - Decodes `controle` every edge.
  - On SHLN/SHRN with `quantidade`=0: `saida` and `carry` are unchanged, `pronto` pulses on the next cycle, and `ocupado` stays low.
  - On SHLN/SHRN with `quantidade`=n>0: latch direction, `contador`←n, `ocupado`←1, then go to DESLOCANDO. No shift happens on the accepting edge.
- DESLOCANDO
  - Each edge: shift one bit and decrement `contador`.
  - On the edge where `contador` goes 1→0: `ocupado`←0, `pronto`←1 for exactly one cycle, return to OCIOSO.
  - `controle`, `acumulador` and `quantidade` are ignored throughout; CLEAR does not abort.
- `quantidade` > `WIDTH`: clamped to `WIDTH`.

Reset (any time, including mid-shift):
- `saida`=0, `carry`=0, `ocupado`=0, `pronto`=0, state OCIOSO, `contador`=0.
- `zero`=1 follows from `saida`=0.

## Timing
- Single-cycle ops: result visible on `saida`/`carry` after the edge that samples the opcode (latency 1).
- Multi-cycle, n>0: `ocupado` is high after the accepting edge and stays high for exactly n cycles. Final `saida` and `pronto`=1 appear together after edge n+1 counted from acceptance.
- A new opcode can be accepted on the edge where `pronto` is high, i.e. back-to-back with no gap.
- `zero` is combinational from `saida` and has no extra latency.
- Reset deassertion: the first edge after deassertion decodes `controle` normally.

## Test plan
- Reset/LOAD/HOLD, WIDTH=8:
  - Assert reset mid-cycle → `saida`=0x00, `zero`=1 immediately.
  - LOAD 0xA5 → 0xA5.
  - Opcode 2 or 13 for 3 cycles → 0xA5 held, `carry` unchanged.
- Shift and rotate, starting from 0x81 with `entrada_serial`=0:
  - SHL → 0x02, `carry`=1.
  - Starting again from 0x81, SHR → 0x40, `carry`=1.
  - ROL of 0x81 → 0x03; ROR of 0x81 → 0xC0.
- Arithmetic wrap:
  - INC of 0xFF → 0x00, `carry`=1, `zero`=1.
  - DEC of 0x00 → 0xFF, `carry`=1.
  - INC of 0x10 → 0x11, `carry`=0.
- SHLN, n=3, from 0x0F with `entrada_serial`=1:
  - `ocupado` high for 3 cycles; opcodes issued meanwhile are ignored.
  - Ends at 0x7F, `carry`=0, `pronto` one-cycle pulse.
  - Immediately issue SHRN with n=0 → `pronto` next cycle, `ocupado` stays low, `saida` stays 0x7F.
- Clamp and reset abort:
  - SHRN with `quantidade`=15 at WIDTH=8 → exactly 8 busy cycles.
  - Repeat and assert reset after 2 steps → all outputs 0, then LOAD on the next edge succeeds.
